rev_alu_seq_ctrl: RTL and testbench



---
 rtl/rev_alu_pkg.sv | 31 +++
 rtl/rev_alu_seq_ctrl_slice.sv | 70 +++++++
 rtl/rev_alu_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rev_alu_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rev_alu_pkg.sv
// ---------------------------------------------------------------------------
// rev_alu_pkg
// Shared definitions for the bit-serial reversible ALU sequencer.
//   - OP_* : 3-bit opcodes carried on cmd_op and into the bit slice
//   - state_t : controller FSM states (IDLE / RUN / DONE)
//   - mul_latency() : accept-to-response edge count of a MUL for a width
// ---------------------------------------------------------------------------
package rev_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A MUL runs one full-width serial add per multiplier bit, and the
    // multiplier is half the word wide.
    function automatic int mul_latency(input int width);
        return (width / 2) * width;
    endfunction

endpackage

// File: rtl/rev_alu_seq_ctrl_slice.sv
// ---------------------------------------------------------------------------
// rev_bit_slice
// Purely combinational 1-bit reversible ALU cell.
//   a, b : operand bits          cin : carry (ADD/MUL) or borrow (SUB) in
//   op   : opcode (OP_*)          r   : result bit
//   cout : carry/borrow out, 0 for the logic ops
// ---------------------------------------------------------------------------
module rev_bit_slice
    import rev_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);

    // Two cascaded Peres gates form the full adder:
    // P1(a, b, 0) gives a^b and a&b; P2(a^b, cin, a&b) gives the sum
    // and ((a^b)&cin) ^ (a&b), which is the carry.
    logic peres1_q;
    logic peres1_r;
    logic add_sum;
    logic add_carry;

    assign peres1_q  = a ^ b;
    assign peres1_r  = a & b;
    assign add_sum   = peres1_q ^ cin;
    assign add_carry = (peres1_q & cin) ^ peres1_r;

    // DKG gate (A, B, C, D) = (ctl, a, b, cin). With the control input tied
    // to 1 the R output becomes the borrow of a - b - cin and S the
    // difference bit.
    logic dkg_ctl;
    logic sub_diff;
    logic sub_borrow;

    assign dkg_ctl    = 1'b1;
    assign sub_diff   = a ^ b ^ cin;
    assign sub_borrow = ((dkg_ctl ^ a) & (b ^ cin)) ^ (b & cin);

    // Opcode select. MUL reuses the adder because the controller feeds it
    // the accumulator and the shifted partial product.
    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_ADD,
            OP_MUL: begin
                r    = add_sum;
                cout = add_carry;
            end
            OP_SUB: begin
                r    = sub_diff;
                cout = sub_borrow;
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NAND: r = ~(a & b);
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rev_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rev_alu_seq_ctrl
// Bit-serial sequencer that pushes word-wide ALU commands through a single
// reversible 1-bit slice, LSB first.
//   clk, rst               : clock, synchronous active-high reset
//   cmd_valid / cmd_ready  : command handshake (cmd_op, cmd_a, cmd_b)
//   rsp_valid / rsp_ready  : response handshake (rsp_result, rsp_flag)
//   rsp_flag               : ADD carry-out, SUB borrow-out, else 0
//   busy                   : high while a command is in RUN or DONE
// ---------------------------------------------------------------------------
module rev_alu_seq_ctrl
    import rev_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_flag,
    output logic             busy
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("rev_alu_seq_ctrl: WIDTH must be even and >= 2");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op_reg;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] pass_cnt;

    logic             is_mul;
    logic             last_bit;
    logic             last_pass;
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH-1:0] acc_next;
    logic             slice_a;
    logic             slice_b;
    logic [2:0]       slice_op;
    logic             slice_r;
    logic             slice_cout;

    assign cmd_ready = (state == IDLE) && !rst;
    assign is_mul    = (op_reg == OP_MUL);
    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign last_pass = (pass_cnt == CNT_W'(HALF - 1));

    // Result bits enter at the MSB, so after WIDTH edges the word is
    // aligned. For MUL the accumulator rotates through the same path.
    assign acc_next = {slice_r, acc[WIDTH-1:1]};

    // Partial product of the current MUL pass: the low half of A shifted
    // by the pass index, gated by the matching multiplier bit of B. a_sh
    // and b_sh are held still during MUL, so this is stable for the pass.
    always_comb begin
        mul_addend = '0;
        if (b_sh[pass_cnt]) begin
            mul_addend = {{(WIDTH-HALF){1'b0}}, a_sh[HALF-1:0]} << pass_cnt;
        end
    end

    // Slice input steering: logic/ADD/SUB consume the operand shifters,
    // MUL adds the partial product bit into the rotating accumulator.
    always_comb begin
        slice_a  = a_sh[0];
        slice_b  = b_sh[0];
        slice_op = op_reg;
        if (is_mul) begin
            slice_a  = acc[0];
            slice_b  = mul_addend[bit_cnt];
            slice_op = OP_ADD;
        end
    end

    rev_bit_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .op   (slice_op),
        .r    (slice_r),
        .cout (slice_cout)
    );

    // Controller FSM. All datapath registers, counters and the registered
    // response live here; a reset in any state drops the command silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            op_reg     <= OP_ADD;
            carry      <= 1'b0;
            bit_cnt    <= '0;
            pass_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        a_sh     <= cmd_a;
                        b_sh     <= cmd_b;
                        op_reg   <= cmd_op;
                        carry    <= 1'b0;
                        bit_cnt  <= '0;
                        pass_cnt <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    acc     <= acc_next;
                    carry   <= slice_cout;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (!is_mul) begin
                        a_sh <= a_sh >> 1;
                        b_sh <= b_sh >> 1;
                        if (last_bit) begin
                            state      <= DONE;
                            rsp_valid  <= 1'b1;
                            rsp_result <= acc_next;
                            rsp_flag   <= ((op_reg == OP_ADD) || (op_reg == OP_SUB))
                                          ? slice_cout : 1'b0;
                        end
                    end else if (last_bit) begin
                        // End of a pass: the pass carry-out is dropped and the
                        // next pass starts with a clean carry.
                        carry    <= 1'b0;
                        bit_cnt  <= '0;
                        pass_cnt <= pass_cnt + CNT_W'(1);
                        if (last_pass) begin
                            state      <= DONE;
                            rsp_valid  <= 1'b1;
                            rsp_result <= acc_next;
                            rsp_flag   <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rev_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rev_alu_seq_ctrl
// Directed bench for rev_alu_seq_ctrl. The driver pushes the hand-computed
// response of each accepted command into a queue; an independent monitor
// pops and compares whenever a new response appears.
// ---------------------------------------------------------------------------
module tb_rev_alu_seq_ctrl;
    import rev_alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_flag;
    logic             busy;

    rev_alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .busy       (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             flag;
        int               latency;
        int               accept;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Free-running clock and an edge counter used to measure latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // One comparison: counts it and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, actual, expected, cycle);
        end
    endtask

    // Waits (bounded) for cmd_ready, presents one command for one edge and,
    // when a response is expected, queues it with the accepting edge number.
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] exp_res,
                                 input logic exp_flag, input bit expect_rsp);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        if (expect_rsp) begin
            e.result  = exp_res;
            e.flag    = exp_flag;
            e.latency = (op == OP_MUL) ? mul_latency(WIDTH) : WIDTH;
            e.accept  = cycle;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: a rising rsp_valid is a new response and is scored against
    // the queue head; while it stays up the response must be held and no
    // command may be accepted.
    exp_t cur;
    bit   resp_open = 1'b0;
    bit   cur_ok    = 1'b0;

    always @(negedge clk) begin
        if (!rsp_valid) begin
            resp_open = 1'b0;
        end else if (!resp_open) begin
            resp_open = 1'b1;
            if (exp_q.size() == 0) begin
                cur_ok = 1'b0;
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                cur_ok = 1'b1;
                cur = exp_q.pop_front();
                checkOutput("rsp_result", 32'(rsp_result), 32'(cur.result));
                checkOutput("rsp_flag", 32'(rsp_flag), 32'(cur.flag));
                checkOutput("rsp_latency", 32'(cycle - cur.accept), 32'(cur.latency));
            end
        end else if (cur_ok) begin
            checkOutput("held_result", 32'(rsp_result), 32'(cur.result));
            checkOutput("held_flag", 32'(rsp_flag), 32'(cur.flag));
            checkOutput("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
        end
    end

    // Bounded wait for the controller to return to idle.
    task automatic waitIdle(input string name);
        int waited;
        waited = 0;
        while ((busy || exp_q.size() != 0) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             flag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int seen;
        int waited;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_ADD;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;

        // Reset values while rst is still high.
        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("reset_rsp_flag", 32'(rsp_flag), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed vectors with hand-computed results.
        vecs.push_back('{OP_ADD,  8'hC8, 8'h64, 8'h2C, 1'b1});
        vecs.push_back('{OP_SUB,  8'h05, 8'h07, 8'hFE, 1'b1});
        vecs.push_back('{OP_SUB,  8'h07, 8'h05, 8'h02, 1'b0});
        vecs.push_back('{OP_MUL,  8'h3D, 8'hAB, 8'h8F, 1'b0});
        vecs.push_back('{OP_MUL,  8'h3D, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{OP_NAND, 8'hF0, 8'hCC, 8'h3F, 1'b0});
        vecs.push_back('{OP_XNOR, 8'hF0, 8'hCC, 8'hC3, 1'b0});
        vecs.push_back('{OP_AND,  8'hF0, 8'hCC, 8'hC0, 1'b0});
        vecs.push_back('{OP_XOR,  8'hF0, 8'hCC, 8'h3C, 1'b0});
        vecs.push_back('{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1});
        vecs.push_back('{OP_MUL,  8'h0F, 8'h0F, 8'hE1, 1'b0});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                          vecs[i].flag, 1'b1);
        end
        waitIdle("idle_after_vectors");

        // Backpressure: hold the response for 5 cycles while a second
        // command waits on the bus.
        rsp_ready = 1'b0;
        applyStimulus(OP_XNOR, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b1);
        waited = 0;
        while (!rsp_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_OR;
        cmd_a     = 8'h0F;
        cmd_b     = 8'h30;
        repeat (5) @(negedge clk);
        checkOutput("bp_still_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_valid_dropped", 32'(rsp_valid), 32'd0);
        checkOutput("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("bp_held_cmd_taken", 32'(busy), 32'd1);
        begin
            exp_t e;
            e.result  = 8'h3F;
            e.flag    = 1'b0;
            e.latency = WIDTH;
            e.accept  = cycle;
            exp_q.push_back(e);
        end
        waitIdle("idle_after_backpressure");

        // Abort a MUL with reset on its 10th run edge.
        applyStimulus(OP_MUL, 8'h3D, 8'hAB, 8'h00, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("abort_rsp_flag", 32'(rsp_flag), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checkOutput("no_rsp_after_abort", 32'(seen), 32'd0);
        applyStimulus(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b1);
        waitIdle("idle_at_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
